exec_unit: RTL and testbench

EXEC_UNIT -- requirements
Module: exec_unit

---
 rtl/simple_processor_pkg.sv | 37 +++
 rtl/exec_unit_if.sv | 30 +++
 rtl/exec_alu.sv | 59 +++++
 rtl/exec_unit.sv | 110 +++++++++++
 tb/tb_exec_unit.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/simple_processor_pkg.sv
// Shared operation encodings and execution-unit state type for the simple processor.
// Imported by exec_alu, exec_unit and exec_unit_if; no block keeps a private copy.
package simple_processor_pkg;

   typedef enum logic [3:0] {
      FUNC_AND  = 4'd0,
      FUNC_OR   = 4'd1,
      FUNC_XOR  = 4'd2,
      FUNC_NOT  = 4'd3,
      FUNC_ADD  = 4'd4,
      FUNC_SUB  = 4'd5,
      FUNC_ADDI = 4'd6,
      FUNC_SLL  = 4'd7,
      FUNC_SLR  = 4'd8,
      FUNC_SLLI = 4'd9,
      FUNC_SLRI = 4'd10
   } func_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_HOLD  = 2'd2
   } exec_state_t;

   function automatic logic is_shift_op(input func_t f);
      return f inside {FUNC_SLL, FUNC_SLR, FUNC_SLLI, FUNC_SLRI};
   endfunction

   function automatic logic is_left_shift(input func_t f);
      return f inside {FUNC_SLL, FUNC_SLLI};
   endfunction

   function automatic logic uses_imm_shamt(input func_t f);
      return f inside {FUNC_SLLI, FUNC_SLRI};
   endfunction

endpackage

// File: rtl/exec_unit_if.sv
// Request/result bundle of the execution unit; signal suffixes are from the unit's view.
// Handshake: a beat transfers on a rising clk_i edge where valid and ready are both high;
// the sender holds its payload while valid is high and ready is low.
interface exec_unit_if #(
   parameter int DATA_WIDTH = 32,
   parameter int IMM_WIDTH  = 6
) ();

   logic                          in_valid_i;
   logic                          in_ready_o;
   simple_processor_pkg::func_t   func_i;
   logic [DATA_WIDTH-1:0]         rs1_data_i;
   logic [DATA_WIDTH-1:0]         rs2_data_i;
   logic [IMM_WIDTH-1:0]          imm_i;
   logic                          out_valid_o;
   logic                          out_ready_i;
   logic [DATA_WIDTH-1:0]         rd_data_o;
   logic                          zero_o;

   modport slave (
      input  in_valid_i, func_i, rs1_data_i, rs2_data_i, imm_i, out_ready_i,
      output in_ready_o, out_valid_o, rd_data_o, zero_o
   );

   modport master (
      output in_valid_i, func_i, rs1_data_i, rs2_data_i, imm_i, out_ready_i,
      input  in_ready_o, out_valid_o, rd_data_o, zero_o
   );

endinterface

// File: rtl/exec_alu.sv
// Combinational datapath: logic, add/sub and shifts (barrel when EXEC_BARREL_SHIFT_EN is
// defined, otherwise shifts pass rs1 through and a separate one-bit step port is used).
module exec_alu
   import simple_processor_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int IMM_WIDTH  = 6,
   localparam int SHAMT_W   = $clog2(DATA_WIDTH)
) (
   input  func_t                 func_i,
   input  logic [DATA_WIDTH-1:0] rs1_i,
   input  logic [DATA_WIDTH-1:0] rs2_i,
   input  logic [IMM_WIDTH-1:0]  imm_i,
   output logic [DATA_WIDTH-1:0] result_o,
   output logic [SHAMT_W-1:0]    shamt_o,
   input  logic [DATA_WIDTH-1:0] step_data_i,
   input  logic                  step_left_i,
   output logic [DATA_WIDTH-1:0] step_data_o
);

   logic [DATA_WIDTH-1:0] imm_ext;
   logic [DATA_WIDTH-1:0] shl_val;
   logic [DATA_WIDTH-1:0] shr_val;

   assign imm_ext = DATA_WIDTH'($signed(imm_i));

   // Only the low log2(DATA_WIDTH) bits of the shift source count.
   assign shamt_o = uses_imm_shamt(func_i) ? imm_ext[SHAMT_W-1:0] : rs2_i[SHAMT_W-1:0];

`ifdef EXEC_BARREL_SHIFT_EN
   assign shl_val = rs1_i << shamt_o;
   assign shr_val = rs1_i >> shamt_o;
`else
   // The FSM performs the shift; a zero-amount shift completes with rs1 unchanged.
   assign shl_val = rs1_i;
   assign shr_val = rs1_i;
`endif

   always_comb begin
      result_o = '0;
      case (func_i)
         FUNC_AND:  result_o = rs1_i & rs2_i;
         FUNC_OR:   result_o = rs1_i | rs2_i;
         FUNC_XOR:  result_o = rs1_i ^ rs2_i;
         FUNC_NOT:  result_o = ~rs1_i;
         FUNC_ADD:  result_o = rs1_i + rs2_i;
         FUNC_SUB:  result_o = rs1_i - rs2_i;
         FUNC_ADDI: result_o = rs1_i + imm_ext;
         FUNC_SLL:  result_o = shl_val;
         FUNC_SLLI: result_o = shl_val;
         FUNC_SLR:  result_o = shr_val;
         FUNC_SLRI: result_o = shr_val;
         default:   result_o = '0;
      endcase
   end

   assign step_data_o = step_left_i ? (step_data_i << 1) : (step_data_i >> 1);

endmodule

// File: rtl/exec_unit.sv
// Execution unit: request/result handshake FSM, iterative shift counter and result register.
// Define EXEC_BARREL_SHIFT_EN to complete all shifts in one cycle (SHIFT is then never used).
module exec_unit
   import simple_processor_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int IMM_WIDTH  = 6
) (
   input  logic        clk_i,
   input  logic        arst_ni,
   exec_unit_if.slave  bus,
   output exec_state_t dbg_state_o
);

   localparam int SHAMT_W = $clog2(DATA_WIDTH);

   exec_state_t           state_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  zero_q;
   logic                  valid_q;
   logic [SHAMT_W-1:0]    cnt_q;
   logic                  left_q;

   logic [DATA_WIDTH-1:0] alu_result;
   logic [SHAMT_W-1:0]    shamt;
   logic [DATA_WIDTH-1:0] step_data;
   logic                  accept;
   logic                  start_iter;

   exec_alu #(
      .DATA_WIDTH (DATA_WIDTH),
      .IMM_WIDTH  (IMM_WIDTH)
   ) u_alu (
      .func_i      (bus.func_i),
      .rs1_i       (bus.rs1_data_i),
      .rs2_i       (bus.rs2_data_i),
      .imm_i       (bus.imm_i),
      .result_o    (alu_result),
      .shamt_o     (shamt),
      .step_data_i (data_q),
      .step_left_i (left_q),
      .step_data_o (step_data)
   );

   // Ready depends on state and out_ready_i only, never on in_valid_i.
   assign bus.in_ready_o = (state_q == ST_IDLE) ||
                           ((state_q == ST_HOLD) && bus.out_ready_i);
   assign accept = bus.in_valid_i && bus.in_ready_o;

`ifdef EXEC_BARREL_SHIFT_EN
   assign start_iter = 1'b0;
`else
   assign start_iter = is_shift_op(bus.func_i) && (shamt != '0);
`endif

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
         zero_q  <= 1'b0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
         left_q  <= 1'b0;
      end else if (accept) begin
         if (start_iter) begin
            state_q <= ST_SHIFT;
            data_q  <= bus.rs1_data_i;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= shamt;
            left_q  <= is_left_shift(bus.func_i);
         end else begin
            state_q <= ST_HOLD;
            data_q  <= alu_result;
            zero_q  <= (alu_result == '0);
            valid_q <= 1'b1;
         end
      end else begin
         case (state_q)
            ST_IDLE: ;
            ST_SHIFT: begin
               // One bit position per cycle; the last step lands the result in HOLD.
               data_q <= step_data;
               cnt_q  <= cnt_q - 1'b1;
               if (cnt_q == SHAMT_W'(1)) begin
                  state_q <= ST_HOLD;
                  zero_q  <= (step_data == '0);
                  valid_q <= 1'b1;
               end
            end
            ST_HOLD: begin
               if (bus.out_ready_i) begin
                  state_q <= ST_IDLE;
                  valid_q <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.out_valid_o = valid_q;
   assign bus.rd_data_o   = data_q;
   assign bus.zero_o      = zero_q;
   assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit (default iterative-shift build): timing checks inline,
// result values through an expected queue popped on every output transfer.
module tb_exec_unit;
   import simple_processor_pkg::*;

   localparam int DW = 32;
   localparam int IW = 6;

   typedef struct {
      func_t       f;
      logic [31:0] a;
      logic [31:0] b;
      logic [5:0]  imm;
      logic [31:0] r;
   } vec_t;

   logic        clk = 1'b0;
   logic        arst_n = 1'b0;
   exec_state_t dbg_state;
   int          n_cmp = 0;
   int          n_err = 0;
   logic [32:0] exp_q[$];

   exec_unit_if #(.DATA_WIDTH(DW), .IMM_WIDTH(IW)) bus ();

   exec_unit #(.DATA_WIDTH(DW), .IMM_WIDTH(IW)) dut (
      .clk_i       (clk),
      .arst_ni     (arst_n),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic drive(input func_t f, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] imm);
      bus.in_valid_i = 1'b1;
      bus.func_i     = f;
      bus.rs1_data_i = a;
      bus.rs2_data_i = b;
      bus.imm_i      = imm;
   endtask

   task automatic idle_req();
      bus.in_valid_i = 1'b0;
   endtask

   task automatic push_exp(input logic [31:0] d);
      exp_q.push_back({(d == 32'h0), d});
   endtask

   task automatic wait_valid(input string tag, input int max_cycles, output int n);
      n = 0;
      while (!bus.out_valid_o && n < max_cycles) begin
         @(negedge clk);
         #1;
         n++;
      end
      check_eq(tag, 33'(bus.out_valid_o), 33'(1));
   endtask

   // scoreboard: every output transfer must match the oldest expected result
   initial begin : monitor
      logic [32:0] e;
      forever begin
         @(negedge clk);
         #2;
         if (arst_n && bus.out_valid_o && bus.out_ready_i) begin
            check_eq("sb_pending", 33'(exp_q.size() != 0), 33'(1));
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check_eq("sb_result", {bus.zero_o, bus.rd_data_o}, e);
            end
         end
      end
   end

   initial begin : stimulus
      func_t       b2b_f[3];
      logic [31:0] b2b_r[3];
      vec_t        arith[5];
      int          n;
      logic        seen;

      b2b_f = '{FUNC_OR, FUNC_XOR, FUNC_NOT};
      b2b_r = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5A5A_5A5A};
      arith = '{
         '{FUNC_ADDI, 32'h0000_0001, 32'h0000_0000, 6'd3,       32'h0000_0004},
         '{FUNC_ADDI, 32'h0000_0001, 32'h0000_0000, 6'b111111,  32'h0000_0000},
         '{FUNC_SUB,  32'h0000_0001, 32'h0000_0002, 6'd0,       32'hFFFF_FFFF},
         '{FUNC_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 6'd0,       32'h0000_0000},
         '{func_t'(4'd13), 32'h1234_5678, 32'h0000_0001, 6'd5,  32'h0000_0000}
      };

      bus.in_valid_i  = 1'b0;
      bus.func_i      = FUNC_AND;
      bus.rs1_data_i  = '0;
      bus.rs2_data_i  = '0;
      bus.imm_i       = '0;
      bus.out_ready_i = 1'b0;

      // reset state
      repeat (2) @(negedge clk);
      #1;
      check_eq("rst_valid", 33'(bus.out_valid_o), 33'(0));
      check_eq("rst_rd",    33'(bus.rd_data_o),   33'(0));
      check_eq("rst_zero",  33'(bus.zero_o),      33'(0));
      check_eq("rst_state", 33'(dbg_state),       33'(ST_IDLE));
      @(negedge clk);
      arst_n = 1'b1;
      #1;
      check_eq("rst_ready", 33'(bus.in_ready_o), 33'(1));

      // AND, one-cycle latency, held until drained
      @(negedge clk);
      drive(FUNC_AND, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 6'd0);
      push_exp(32'h0);
      #1;
      check_eq("and_in_ready", 33'(bus.in_ready_o), 33'(1));
      @(negedge clk);
      idle_req();
      #1;
      check_eq("and_valid",      33'(bus.out_valid_o), 33'(1));
      check_eq("and_rd",         33'(bus.rd_data_o),   33'(0));
      check_eq("and_zero",       33'(bus.zero_o),      33'(1));
      check_eq("and_hold_ready", 33'(bus.in_ready_o),  33'(0));
      @(negedge clk);
      bus.out_ready_i = 1'b1;
      #1;
      check_eq("drain_ready", 33'(bus.in_ready_o), 33'(1));
      @(negedge clk);
      #1;
      check_eq("drain_valid", 33'(bus.out_valid_o), 33'(0));
      check_eq("drain_state", 33'(dbg_state),       33'(ST_IDLE));

      // back-to-back OR, XOR, NOT
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive(b2b_f[i], 32'hA5A5_A5A5, 32'h5A5A_5A5A, 6'd0);
         push_exp(b2b_r[i]);
         #1;
         check_eq("b2b_ready", 33'(bus.in_ready_o), 33'(1));
         if (i > 0) check_eq("b2b_valid", 33'(bus.out_valid_o), 33'(1));
      end
      @(negedge clk);
      idle_req();
      #1;
      check_eq("b2b_last_valid", 33'(bus.out_valid_o), 33'(1));
      @(negedge clk);
      #1;
      check_eq("b2b_done", 33'(bus.out_valid_o), 33'(0));

      // add/sub/immediate and unlisted encoding, streamed
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         drive(arith[i].f, arith[i].a, arith[i].b, arith[i].imm);
         push_exp(arith[i].r);
         #1;
      end
      @(negedge clk);
      idle_req();
      #1;
      check_eq("arith_last_valid", 33'(bus.out_valid_o), 33'(1));
      @(negedge clk);
      #1;
      check_eq("arith_done", 33'(bus.out_valid_o), 33'(0));

      // SLR by 2: three-cycle latency, two busy cycles
      @(negedge clk);
      drive(FUNC_SLR, 32'h0000_0004, 32'h0000_0002, 6'd0);
      push_exp(32'h0000_0001);
      #1;
      check_eq("slr_acc_ready", 33'(bus.in_ready_o), 33'(1));
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         idle_req();
         #1;
         check_eq("slr_busy_ready", 33'(bus.in_ready_o),  33'(0));
         check_eq("slr_busy_valid", 33'(bus.out_valid_o), 33'(0));
      end
      @(negedge clk);
      #1;
      check_eq("slr_valid", 33'(bus.out_valid_o), 33'(1));
      @(negedge clk);
      #1;

      // SLRI by 0: no wait cycles
      @(negedge clk);
      drive(FUNC_SLRI, 32'h0000_0080, 32'hFFFF_FFFF, 6'd0);
      push_exp(32'h0000_0080);
      #1;
      @(negedge clk);
      idle_req();
      #1;
      check_eq("slri0_valid", 33'(bus.out_valid_o), 33'(1));
      @(negedge clk);
      #1;

      // SLL with rs2=0x21: upper amount bits ignored, shift by 1
      @(negedge clk);
      drive(FUNC_SLL, 32'h0000_0001, 32'h0000_0021, 6'd0);
      push_exp(32'h0000_0002);
      #1;
      @(negedge clk);
      idle_req();
      #1;
      check_eq("sll33_busy", 33'(bus.out_valid_o), 33'(0));
      @(negedge clk);
      #1;
      check_eq("sll33_valid", 33'(bus.out_valid_o), 33'(1));
      @(negedge clk);
      #1;

      // SLLI with negative immediate: sext(111100) low 5 bits = 28
      @(negedge clk);
      drive(FUNC_SLLI, 32'h0000_0001, 32'h0, 6'b111100);
      push_exp(32'h1000_0000);
      #1;
      @(negedge clk);
      idle_req();
      #1;
      wait_valid("slli_valid", 40, n);
      check_eq("slli_lat", 33'(n), 33'(28));
      @(negedge clk);
      #1;

      // backpressure: result held, new request refused for 5 cycles
      @(negedge clk);
      bus.out_ready_i = 1'b0;
      drive(FUNC_ADD, 32'h0000_0005, 32'h0000_0007, 6'd0);
      push_exp(32'h0000_000C);
      #1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         drive(FUNC_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 6'd0);
         #1;
         check_eq("bp_valid", 33'(bus.out_valid_o), 33'(1));
         check_eq("bp_rd",    33'(bus.rd_data_o),   33'(32'h0000_000C));
         check_eq("bp_ready", 33'(bus.in_ready_o),  33'(0));
      end
      @(negedge clk);
      bus.out_ready_i = 1'b1;
      push_exp(32'hFF00_FF00);
      #1;
      check_eq("bp_release_ready", 33'(bus.in_ready_o), 33'(1));
      @(negedge clk);
      idle_req();
      #1;
      check_eq("bp_xor_valid", 33'(bus.out_valid_o), 33'(1));
      check_eq("bp_xor_rd",    33'(bus.rd_data_o),   33'(32'hFF00_FF00));
      @(negedge clk);
      #1;
      check_eq("bp_done", 33'(bus.out_valid_o), 33'(0));

      // reset on the 5th SHIFT cycle of SLL by 20: discarded, no result
      @(negedge clk);
      drive(FUNC_SLL, 32'h0000_0001, 32'd20, 6'd0);
      #1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         idle_req();
         #1;
         check_eq("rmid_state", 33'(dbg_state), 33'(ST_SHIFT));
      end
      @(negedge clk);
      arst_n = 1'b0;
      #1;
      check_eq("rmid_valid", 33'(bus.out_valid_o), 33'(0));
      check_eq("rmid_rd",    33'(bus.rd_data_o),   33'(0));
      check_eq("rmid_zero",  33'(bus.zero_o),      33'(0));
      check_eq("rmid_idle",  33'(dbg_state),       33'(ST_IDLE));
      @(negedge clk);
      arst_n = 1'b1;
      #1;
      check_eq("rmid_ready", 33'(bus.in_ready_o), 33'(1));
      seen = 1'b0;
      repeat (30) begin
         @(negedge clk);
         #1;
         if (bus.out_valid_o) seen = 1'b1;
      end
      check_eq("rmid_no_result", 33'(seen), 33'(0));

      // final report
      check_eq("q_empty", 33'(exp_q.size()), 33'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
